// File: rtl/mem_responder_pkg.sv
// Shared types and default sizing for the memory responder.
package mem_responder_pkg;
    localparam int ADDR_W  = 48;
    localparam int DATA_W  = 64;
    // Widest word index a 48-bit byte address can carry (8-byte words).
    localparam int IDX_MAX = ADDR_W - 3;

    localparam int DEF_MEM_WORDS    = 1024;
    localparam int DEF_BURST_LEN    = 8;
    localparam int DEF_READ_LATENCY = 4;
    localparam int DEF_REQ_DEPTH    = 4;

    typedef enum logic [1:0] {IDLE, LAT, BURST} state_t;

    // One queued request; idx is already reduced to a word index.
    typedef struct packed {
        logic               write;
        logic [IDX_MAX-1:0] idx;
        logic [DATA_W-1:0]  data;
    } req_t;
endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a requester (master) and the responder (slave).
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic              mem_req_valid;
    logic              mem_req_write;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              mem_resp_last;
    logic              mem_resp_ready;

    modport master (
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data, mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_last
    );

    modport slave (
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data, mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_last
    );
endinterface

// File: rtl/mem_req_fifo.sv
// In-order request queue; pushes when full and pops when empty are ignored.
module mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = store[rd_ptr];

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage needs no reset: count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/mem_responder.sv
// Memory model answering reads with critical-word-first wrapping bursts.
module mem_responder import mem_responder_pkg::*; #(
    parameter int MEM_WORDS    = DEF_MEM_WORDS,
    parameter int BURST_LEN    = DEF_BURST_LEN,
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    parameter int REQ_DEPTH    = DEF_REQ_DEPTH
) (
    input  logic            clk,
    input  logic            reset_n,
    mem_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int B_W   = $clog2(BURST_LEN);
    localparam int LW    = $clog2(READ_LATENCY);
    localparam int CW    = $clog2(REQ_DEPTH) + 1;
    localparam logic [IDX_W-1:0] BMASK = IDX_W'(BURST_LEN - 1);

    // Word k of the burst aligned block around base, starting at base.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input logic [B_W-1:0]   k);
        return (base & ~BMASK) | ((base + IDX_W'(k)) & BMASK);
    endfunction

    state_t            state;
    logic [IDX_W-1:0]  idx_q, mem_addr, head_idx;
    logic [LW-1:0]     lat_q;
    logic [B_W-1:0]    beat_q, beat_nxt;
    logic              resp_valid_q, resp_last_q, rdy_q;
    logic [DATA_W-1:0] resp_data_q;
    logic [DATA_W-1:0] mem [MEM_WORDS];

    req_t              push_ent, head;
    logic              push, pop, full, empty, mem_we, req_ready;
    logic [CW-1:0]     count;

    // rdy_q keeps ready low through reset and raises it on the first edge after.
    assign req_ready      = rdy_q && (count != CW'(REQ_DEPTH));
    assign push           = bus.mem_req_valid && req_ready;
    assign push_ent.write = bus.mem_req_write;
    assign push_ent.idx   = IDX_MAX'(bus.mem_req_addr[3 +: IDX_W]);
    assign push_ent.data  = bus.mem_req_data;
    assign head_idx       = head.idx[IDX_W-1:0];
    assign pop            = (state == IDLE) && !empty;
    assign mem_we         = pop && head.write;
    assign beat_nxt       = beat_q + B_W'(1);

    assign bus.mem_req_ready  = req_ready;
    assign bus.mem_resp_valid = resp_valid_q;
    assign bus.mem_resp_data  = resp_data_q;
    assign bus.mem_resp_last  = resp_last_q;

    mem_req_fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_ent),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Single storage port: writes only in IDLE, burst reads only in LAT/BURST.
    always_comb begin
        mem_addr = head_idx;
        case (state)
            LAT:     mem_addr = idx_q;
            BURST:   mem_addr = wrap_idx(idx_q, beat_nxt);
            default: mem_addr = head_idx;
        endcase
    end

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= head.data;
    end

    // Request sequencing and registered response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx_q        <= '0;
            lat_q        <= '0;
            beat_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_data_q  <= '0;
            rdy_q        <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (!empty && !head.write) begin
                        idx_q <= head_idx;
                        lat_q <= LW'(READ_LATENCY - 2);
                        state <= LAT;
                    end
                end
                LAT: begin
                    if (lat_q == '0) begin
                        state        <= BURST;
                        beat_q       <= '0;
                        resp_valid_q <= 1'b1;
                        resp_last_q  <= 1'b0;
                        resp_data_q  <= mem[mem_addr];
                    end else begin
                        lat_q <= lat_q - LW'(1);
                    end
                end
                BURST: begin
                    if (resp_valid_q && bus.mem_resp_ready) begin
                        if (resp_last_q) begin
                            state        <= IDLE;
                            resp_valid_q <= 1'b0;
                            resp_last_q  <= 1'b0;
                        end else begin
                            beat_q      <= beat_nxt;
                            resp_data_q <= mem[mem_addr];
                            resp_last_q <= (beat_nxt == B_W'(BURST_LEN - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address bits outside the word index and the spare index bits are intentionally dropped.
    logic unused_ok;
    assign unused_ok = &{1'b0, full, bus.mem_req_addr[2:0],
                         bus.mem_req_addr[ADDR_W-1:IDX_W+3], head.idx[IDX_MAX-1:IDX_W]};
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with hand-computed burst contents.
module tb_mem_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc, first_cyc;
    logic [63:0] exp_b [8];

    mem_responder_if bus();

    mem_responder dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Issue one request; called and returns at #1 after a rising edge.
    task automatic send(input logic w, input logic [47:0] a, input logic [63:0] d);
        int n = 0;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = w;
        bus.mem_req_addr  = a;
        bus.mem_req_data  = d;
        while (!bus.mem_req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) chk("req_accept", 64'(bus.mem_req_ready), 64'd1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.mem_req_valid = 1'b0;
    endtask

    // Collect a full burst against exp_b, optionally stalling one beat.
    task automatic recv(input int stall_beat, input int stall_n);
        bus.mem_resp_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            int n = 0;
            while (!bus.mem_resp_valid && n < 50) begin
                @(posedge clk); #1; n++;
            end
            if (!bus.mem_resp_valid) chk($sformatf("beat%0d_valid", b), 64'(bus.mem_resp_valid), 64'd1);
            if (b == 0) first_cyc = cyc;
            chk($sformatf("beat%0d_data", b), bus.mem_resp_data, exp_b[b]);
            chk($sformatf("beat%0d_last", b), 64'(bus.mem_resp_last), 64'(b == 7));
            if (b == stall_beat) begin
                bus.mem_resp_ready = 1'b0;
                repeat (stall_n) begin
                    @(posedge clk); #1;
                    chk("stall_valid", 64'(bus.mem_resp_valid), 64'd1);
                    chk("stall_data", bus.mem_resp_data, exp_b[b]);
                    chk("stall_last", 64'(bus.mem_resp_last), 64'(b == 7));
                end
                bus.mem_resp_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("valid_after_last", 64'(bus.mem_resp_valid), 64'd0);
    endtask

    initial begin
        int seen;
        bus.mem_req_valid  = 1'b0;
        bus.mem_req_write  = 1'b0;
        bus.mem_req_addr   = '0;
        bus.mem_req_data   = '0;
        bus.mem_resp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.mem_req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.mem_resp_valid), 64'd0);
        chk("rst_resp_last", 64'(bus.mem_resp_last), 64'd0);
        chk("rst_resp_data", bus.mem_resp_data, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(bus.mem_req_ready), 64'd1);

        // Preload three regions
        for (int k = 0; k < 8; k++) begin
            send(1'b1, 48'h100 + 48'(8 * k), 64'hA5A5_0000_0000_0000 + 64'(k));
            send(1'b1, 48'h200 + 48'(8 * k), 64'h0200_0000_0000_0000 + 64'(k));
            send(1'b1, 48'h300 + 48'(8 * k), 64'h0300_0000_0000_0000 + 64'(k));
        end
        repeat (3) @(posedge clk);
        #1;

        // Wrapped burst from 0x118 and first-beat latency
        for (int k = 0; k < 8; k++) exp_b[k] = 64'hA5A5_0000_0000_0000 + 64'((k + 3) % 8);
        send(1'b0, 48'h118, 64'd0);
        recv(-1, 0);
        chk("latency", 64'(first_cyc - acc_cyc), 64'd4);

        // Five-cycle stall on beat 2
        for (int k = 0; k < 8; k++) exp_b[k] = 64'hA5A5_0000_0000_0000 + 64'(k);
        send(1'b0, 48'h100, 64'd0);
        recv(2, 5);

        // Write then immediate read of the same word
        exp_b[0] = 64'hDEAD;
        for (int k = 1; k < 8; k++) exp_b[k] = 64'h0200_0000_0000_0000 + 64'(k);
        send(1'b1, 48'h200, 64'hDEAD);
        send(1'b0, 48'h200, 64'd0);
        recv(-1, 0);

        // Address wrap modulo MEM_WORDS
        for (int k = 0; k < 8; k++) exp_b[k] = 64'hA5A5_0000_0000_0000 + 64'(k);
        send(1'b0, 48'h2100, 64'd0);
        recv(-1, 0);

        // Queue full behind a stalled burst; queued writes must not disturb it
        for (int k = 0; k < 8; k++) exp_b[k] = 64'h0300_0000_0000_0000 + 64'(k);
        bus.mem_resp_ready = 1'b0;
        send(1'b0, 48'h300, 64'd0);
        seen = 0;
        while (!bus.mem_resp_valid && seen < 50) begin
            @(posedge clk); #1; seen++;
        end
        chk("stalled_beat0", bus.mem_resp_data, exp_b[0]);
        for (int j = 0; j < 4; j++) send(1'b1, 48'h300 + 48'(8 * j), 64'h3000 + 64'(j));
        chk("full_ready", 64'(bus.mem_req_ready), 64'd0);
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b1;
        bus.mem_req_addr  = 48'h320;
        bus.mem_req_data  = 64'h3004;
        repeat (3) begin
            @(posedge clk); #1;
            chk("fifth_blocked", 64'(bus.mem_req_ready), 64'd0);
        end
        bus.mem_req_valid = 1'b0;
        recv(-1, 0);
        send(1'b1, 48'h320, 64'h3004);
        for (int k = 0; k < 8; k++)
            exp_b[k] = (k < 5) ? 64'h3000 + 64'(k) : 64'h0300_0000_0000_0000 + 64'(k);
        send(1'b0, 48'h300, 64'd0);
        recv(-1, 0);

        // Reset on beat 3 drops the burst and the queued read
        for (int k = 0; k < 8; k++) exp_b[k] = 64'hA5A5_0000_0000_0000 + 64'((k + 3) % 8);
        send(1'b0, 48'h118, 64'd0);
        send(1'b0, 48'h200, 64'd0);
        bus.mem_resp_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            seen = 0;
            while (!bus.mem_resp_valid && seen < 50) begin
                @(posedge clk); #1; seen++;
            end
            chk($sformatf("pre_rst_beat%0d", b), bus.mem_resp_data, exp_b[b]);
            if (b < 3) begin
                @(posedge clk); #1;
            end
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.mem_resp_valid), 64'd0);
        chk("midrst_last", 64'(bus.mem_resp_last), 64'd0);
        chk("midrst_ready", 64'(bus.mem_req_ready), 64'd0);
        chk("midrst_data", bus.mem_resp_data, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst2", 64'(bus.mem_req_ready), 64'd1);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.mem_resp_valid) seen++;
        end
        chk("queue_dropped", 64'(seen), 64'd0);
        send(1'b0, 48'h118, 64'd0);
        recv(-1, 0);
        chk("latency_after_rst", 64'(first_cyc - acc_cyc), 64'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 64-bit words of backing storage (power of 2).
REQ-002 SHALL have parameter BURST_LEN, default 8, meaning the number of beats per read response (power of 2, at least 2).
REQ-003 SHALL have parameter READ_LATENCY, default 4, meaning the cycles from read acceptance to first beat valid (at least 2).
REQ-004 SHALL have parameter REQ_DEPTH, default 4, meaning the request queue entries (power of 2).
REQ-005 SHALL have ports, one per line as name direction width meaning:
clk  in  1  single clock, all logic on rising edge;
reset_n  in  1  asynchronous active-low reset;
mem_req_valid  in  1  request present;
mem_req_write  in  1  1 = write, 0 = read;
mem_req_addr  in  48  byte address;
mem_req_data  in  64  write data;
mem_req_ready  out  1  request accepted when valid and ready are both high;
mem_resp_valid  out  1  read beat present;
mem_resp_data  out  64  read beat data;
mem_resp_last  out  1  final beat of the burst;
mem_resp_ready  in  1  beat consumed when valid and ready are both high.

Function
REQ-006 SHALL compute word index = mem_req_addr[3 +: log2(MEM_WORDS)]; higher address bits are ignored, so accesses wrap modulo MEM_WORDS.
REQ-007 SHALL enqueue {write, word index, data} into an in-order FIFO on each request handshake; mem_req_ready = (count != REQ_DEPTH), driven from registered state only.
REQ-008 SHALL process FIFO entries strictly in arrival order; a read SHALL observe every earlier-accepted write.
REQ-009 SHALL use FSM states IDLE, LAT and BURST.
REQ-010 In IDLE, with a write at the FIFO head, SHALL write the memory and pop in one cycle, stay in IDLE, and produce no response.
REQ-011 In IDLE, with a read at the FIFO head, SHALL latch the index, pop the entry, load the latency counter and go to LAT.
REQ-012 SHALL go LAT->BURST so that mem_resp_valid first rises exactly READ_LATENCY cycles after the accepting edge, when the FIFO was empty and the FSM was in IDLE.
REQ-013 SHALL return beats in critical-word-first wrap order: beat k carries word {idx[hi:b], (idx[b-1:0]+k) mod BURST_LEN}, with b = log2(BURST_LEN).
REQ-014 SHALL hold mem_resp_data, mem_resp_valid and mem_resp_last stable while mem_resp_valid=1 and mem_resp_ready=0.
REQ-015 SHALL assert mem_resp_last only on beat BURST_LEN-1; after that beat's handshake, SHALL go BURST->IDLE with mem_resp_valid low the following cycle.
REQ-016 SHALL deassert mem_resp_valid in IDLE and LAT; mem_resp_data is don't-care when valid is low.
REQ-017 SHALL accept new requests during LAT and BURST up to FIFO capacity; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-018 SHALL NOT allow memory writes during BURST to alter beats of the burst in flight, because writes queue behind the read.

Reset
REQ-019 While reset_n=0, SHALL hold mem_req_ready=0, mem_resp_valid=0, mem_resp_last=0, mem_resp_data=0, FIFO count 0 and FSM in IDLE, asynchronously.
REQ-020 Reset asserted mid-burst SHALL abort the burst and drop all queued requests; memory contents are not reset.
REQ-021 SHALL drive mem_req_ready=1 on the first edge after reset_n deassertion.

Structure
REQ-022 SHALL place the FSM state enum, the request-entry struct and the default parameter constants in package mem_responder_pkg.
REQ-023 SHALL implement the queue as sub-module mem_req_fifo (synchronous, parameterised width and depth, full/empty/count outputs).
REQ-024 SHALL infer the storage as a single-port array, with the one write per cycle and one read per cycle arbitrated by the FSM.

Verification
REQ-025 Write 0xA5A5_0000_0000_000k to addresses 0x100+8k for k=0..7, then read 0x118 -> beats carry k = 3,4,5,6,7,0,1,2; last only on the 8th beat; first valid READ_LATENCY=4 cycles after acceptance.
REQ-026 During a burst, hold mem_resp_ready low for 5 cycles on beat 2 -> data, valid and last remain unchanged, and no beat is lost or duplicated.
REQ-027 Hold the response stalled while issuing 5 back-to-back requests -> 4 accepted, mem_req_ready=0 on the 5th until a pop, then the 5th is accepted.
REQ-028 Issue a write of 0xDEAD to 0x200, then immediately a read of 0x200 -> beat 0 = 0xDEAD.
REQ-029 Read address 0x2000+0x100 with MEM_WORDS=1024 -> returns the same data as address 0x100 (wrap).
REQ-030 Assert reset_n low on beat 3 -> valid drops immediately, the queue empties, and a new read after reset completes normally.
